ps2_rx_fifo: RTL
================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 device-to-host receiver, successor to the single-byte PS/2 receiver.
//  - Synchronises and glitch-filters the PS/2 clock and data lines.
//  - Checks start, odd-parity and stop bits; times out stalled frames.
//  - Buffers received bytes in a first-word-fall-through FIFO with a valid/ready pop port.
//  - Sits between the PS/2 pins and the keyboard scan-code consumer logic.
// PARAMETERS
//  FIFO_DEPTH     8      byte entries in the FIFO; power of 2, >=2
//  SYNC_STAGES    2      flops in the input synchronisers on SDA/SCL; >=2
//  FILTER_LEN     4      consecutive equal SCL samples needed to change filtered SCL; >=1
//  TIMEOUT_CYCLES 50000  CLOCK cycles allowed between SCL falling edges inside a frame
// PORTS
//  CLOCK      in   1                       system clock; all logic on its rising edge
//  RESET_N    in   1                       asynchronous, active-low reset
//  SDA        in   1                       PS/2 data line, asynchronous
//  SCL        in   1                       PS/2 clock line, asynchronous
//  RX_data    out  8                       FIFO head byte; valid while RX_valid=1
//  RX_valid   out  1                       FIFO not empty
//  RX_ready   in   1                       consumer pops head when RX_valid&RX_ready
//  FIFO_count out  $clog2(FIFO_DEPTH)+1    occupied entries, 0..FIFO_DEPTH
//  ERR_flags  out  4                       sticky flags: {timeout, overflow, frame, parity}
//  ERR_CLR    in   1                       1-cycle pulse clears all ERR_flags
// BEHAVIOUR
//  Reset (async, RESET_N=0):
//  - Sync flops and filtered SCL = 1; state=IDLE; bit counter and timer = 0.
//  - FIFO empty: RX_valid=0, FIFO_count=0, RX_data=8'h00; ERR_flags=4'b0000.
//  - Reset mid-frame abandons the partial byte; no push, no flags.
//  Input path:
//  - SDA and SCL each pass through SYNC_STAGES flops.
//  - Filtered SCL toggles only after FILTER_LEN consecutive synced samples differ from it.
//  - A "fall" event is the single cycle where filtered SCL goes 1->0.
//  - The synchronised SDA is sampled in that fall cycle.
//  FSM (advances only on fall events, except timeout):
//  - IDLE: fall with SDA=0 -> DATA, bitcnt=0, timer=0. Fall with SDA=1 is ignored.
//  - DATA: shift SDA into bit[bitcnt] (LSB first). After bit 7 -> PARITY.
//  - PARITY: store the parity bit -> STOP.
//  - STOP: evaluate the frame, then -> IDLE.
//    - SDA=0: set frame flag (bit1), no push.
//    - Else ^{data,parity}==0: parity error (see CONFIGURATION).
//    - Else push the byte.
//  - Timeout: timer counts every cycle outside IDLE and clears on each fall event.
//    - When timer reaches TIMEOUT_CYCLES-1: -> IDLE, set timeout flag (bit3), discard the byte.
//  FIFO:
//  - Push happens in the STOP fall cycle. RX_valid/RX_data reflect it on the next cycle.
//  - Push while full with no simultaneous pop: byte dropped, overflow flag (bit2) set, contents unchanged.
//  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
//  - Push and pop in the same cycle when empty: push only (pop needs RX_valid=1).
//  - Read and write pointers wrap modulo FIFO_DEPTH; FIFO_count is registered.
//  - RX_data holds its last value when the FIFO is empty.
//  Flags:
//  - Each ERR_flags bit is sticky; ERR_CLR clears all bits.
//  - A set event in the same cycle as ERR_CLR wins: that bit reads 1.
//  Latency: from an SCL pin falling edge to the fall event = SYNC_STAGES+FILTER_LEN cycles.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN
//  - Defined: a parity failure drops the byte and sets ERR_flags[0].
//  - Undefined: the parity bit is sampled but ignored; the byte is pushed if the stop bit is 1;
//    ERR_flags[0] is tied to 0.
// TESTING
//  Bench: SCL period 80us, CLOCK 50MHz, defaults, macro defined unless noted.
//  1 Frame 0x1C with parity=0, stop=1 -> RX_valid=1, RX_data=8'h1C, FIFO_count=1;
//    pulse RX_ready -> count 0.
//  2 Frame 0x1C with parity=1 -> no push, ERR_flags=4'b0001.
//    Macro undefined -> 0x1C pushed, ERR_flags=0.
//  3 Nine frames 0x01..0x09 with RX_ready=0 -> FIFO_count=8, ERR_flags[2]=1;
//    pops return 0x01..0x08 in order.
//  4 Stop SCL after 4 data bits -> TIMEOUT_CYCLES later state=IDLE, ERR_flags[3]=1;
//    the next full frame 0xA5 (parity 1) is received correctly.
//  5 2-cycle low glitch on SCL while IDLE and mid-frame -> ignored;
//    frame 0x5A still received; stop bit 0 on a later frame -> ERR_flags[1]=1.
//  6 RESET_N low mid-frame and with FIFO_count=3 -> all outputs at reset values;
//    the next frame 0x7E is received alone (FIFO_count=1).

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// Byte pop port of the PS/2 receiver: head byte, valid and ready.
// The master side drives data/valid; the slave side drives ready.
interface ps2_rx_fifo_if;
    logic [7:0] RX_data;
    logic       RX_valid;
    logic       RX_ready;

    modport master (output RX_data, output RX_valid, input RX_ready);
    modport slave  (input RX_data, input RX_valid, output RX_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, SCL glitch filter, frame FSM with
// timeout, and a first-word-fall-through byte FIFO. Parity check: PS2_PARITY_CHECK_EN.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        CLOCK,
    input  logic                        RESET_N,
    input  logic                        SDA,
    input  logic                        SCL,
    ps2_rx_fifo_if.master               rx,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_count,
    output logic [3:0]                  ERR_flags,
    input  logic                        ERR_CLR
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] sda_sync_q, scl_sync_q;
    logic                   sda_s, scl_s;
    logic [FCW-1:0]         filt_cnt_q;
    logic                   scl_filt_q;
    logic                   filt_hit, fall;

    state_t                 state_q;
    logic [2:0]             bitcnt_q;
    logic [TW-1:0]          timer_q;
    logic [7:0]             shift_q;
    logic                   timeout_hit, stop_ev;
    logic                   push, frame_set, par_set;

    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wptr_q, rptr_q, wptr_d, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   valid, pop, full, push_ok, ovf_set;
    logic [3:0]             err_q, err_d;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sda_sync_q <= '1;
            scl_sync_q <= '1;
        end else begin
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
        end
    end

    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    assign scl_s = scl_sync_q[SYNC_STAGES-1];

    // Filtered SCL flips on the FILTER_LEN-th consecutive differing sample.
    assign filt_hit = (scl_s != scl_filt_q) && (filt_cnt_q == FCW'(FILTER_LEN - 1));
    assign fall     = filt_hit && scl_filt_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            filt_cnt_q <= '0;
            scl_filt_q <= 1'b1;
        end else if (scl_s == scl_filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_hit) begin
            filt_cnt_q <= '0;
            scl_filt_q <= ~scl_filt_q;
        end else begin
            filt_cnt_q <= filt_cnt_q + FCW'(1);
        end
    end

    // A fall event in the same cycle as the timer limit keeps the frame alive.
    assign timeout_hit = (state_q != IDLE) && !fall && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            timer_q  <= '0;
        end else if (timeout_hit) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            timer_q <= (state_q == IDLE || fall) ? '0 : timer_q + TW'(1);
            if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!sda_s) begin
                            state_q  <= DATA;
                            bitcnt_q <= '0;
                        end
                    end
                    DATA: begin
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY:  state_q <= STOP;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (fall && state_q == DATA) shift_q[bitcnt_q] <= sda_s;
    end

    assign stop_ev   = fall && (state_q == STOP);
    assign frame_set = stop_ev && !sda_s;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q;
    logic par_bad;

    always_ff @(posedge CLOCK) begin
        if (fall && state_q == PARITY) parity_q <= sda_s;
    end

    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign par_bad = ~(^{shift_q, parity_q});
    assign par_set = stop_ev && sda_s && par_bad;
    assign push    = stop_ev && sda_s && !par_bad;
`else
    assign par_set = 1'b0;
    assign push    = stop_ev && sda_s;
`endif

    always_comb begin
        valid   = (count_q != '0);
        pop     = valid && rx.RX_ready;
        full    = (count_q == CW'(FIFO_DEPTH));
        push_ok = push && (!full || pop);
        ovf_set = push && full && !pop;
        count_d = count_q + CW'(push_ok) - CW'(pop);
        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop);
        // New head is the byte being written when nothing older remains.
        rx_data_d = rx_data_q;
        if (push_ok && count_q == CW'(pop)) begin
            rx_data_d = shift_q;
        end else if (count_d != '0) begin
            rx_data_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push_ok) mem_q[wptr_q] <= shift_q;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rx_data_q <= 8'h00;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rx_data_q <= rx_data_d;
        end
    end

    // A set event overrides a simultaneous clear.
    always_comb begin
        err_d = ERR_CLR ? 4'b0000 : err_q;
        err_d = err_d | {timeout_hit, ovf_set, frame_set, par_set};
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) err_q <= 4'b0000;
        else          err_q <= err_d;
    end

    assign rx.RX_data  = rx_data_q;
    assign rx.RX_valid = valid;
    assign FIFO_count  = count_q;
    assign ERR_flags   = err_q;
endmodule
